// File: rtl/ppu_vblank_nmi_if.sv
// PPU vblank/NMI bus: dot-clock enable, CPU register strobes, raster and interrupt outputs.
// The master side drives the PPU inputs; the slave side is the vblank/NMI block.
interface ppu_vblank_nmi_if;
    logic       dot_en;
    logic       rendering_en;
    logic       ctrl_nmi_en;
    logic       status_rd;
    logic       sprite0_set;
    logic       sprite_ovf_set;
    logic [7:0] ppu_status;
    logic       nmi_level;
    logic       nmi_pulse;
    logic [8:0] dot;
    logic [8:0] scanline;
    logic       odd_frame;

    modport master (
        output dot_en,
        output rendering_en,
        output ctrl_nmi_en,
        output status_rd,
        output sprite0_set,
        output sprite_ovf_set,
        input  ppu_status,
        input  nmi_level,
        input  nmi_pulse,
        input  dot,
        input  scanline,
        input  odd_frame
    );

    modport slave (
        input  dot_en,
        input  rendering_en,
        input  ctrl_nmi_en,
        input  status_rd,
        input  sprite0_set,
        input  sprite_ovf_set,
        output ppu_status,
        output nmi_level,
        output nmi_pulse,
        output dot,
        output scanline,
        output odd_frame
    );
endinterface

// File: rtl/ppu_vblank_nmi.sv
// PPU raster counters, PPUSTATUS flags and NMI request generation.
// Vblank is set/cleared at dot 1 of its lines; a coincident $2002 read suppresses the set.
module ppu_vblank_nmi #(
    parameter int DOTS_PER_LINE   = 341,
    parameter int LINES_PER_FRAME = 262,
    parameter int VBLANK_LINE     = 241,
    parameter int PRERENDER_LINE  = 261
) (
    input logic           clk,
    input logic           rst,
    ppu_vblank_nmi_if.slave bus
);

    localparam logic [8:0] LAST_DOT  = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] SKIP_DOT  = 9'(DOTS_PER_LINE - 2);
    localparam logic [8:0] LAST_LINE = 9'(LINES_PER_FRAME - 1);
    localparam logic [8:0] VBL_LINE  = 9'(VBLANK_LINE);
    localparam logic [8:0] PRE_LINE  = 9'(PRERENDER_LINE);
    localparam logic [8:0] EVT_DOT   = 9'd1;

    logic [8:0] dot_q;
    logic [8:0] line_q;
    logic       odd_q;
    logic       vblank_q;
    logic       sprite0_q;
    logic       ovf_q;
    logic       nmi_level_q;
    logic       nmi_prev_q;
    logic       nmi_pulse_q;

    logic [8:0] dot_n;
    logic [8:0] line_n;
    logic       odd_n;
    logic       vblank_n;
    logic       sprite0_n;
    logic       ovf_n;
    logic       nmi_level_n;
    logic       nmi_pulse_n;

    logic       skip;
    logic       wrap_dot;
    logic       set_ev;
    logic       clr_ev;

    // Next raster position, flag updates and NMI edge detection.
    always_comb begin
        dot_n       = dot_q;
        line_n      = line_q;
        odd_n       = odd_q;
        vblank_n    = vblank_q;
        sprite0_n   = sprite0_q;
        ovf_n       = ovf_q;
        nmi_level_n = 1'b0;
        nmi_pulse_n = 1'b0;

        skip     = bus.rendering_en && odd_q &&
                   (line_q == PRE_LINE) && (dot_q == SKIP_DOT);
        wrap_dot = (dot_q == LAST_DOT);
        set_ev   = bus.dot_en && (line_q == VBL_LINE) && (dot_q == EVT_DOT);
        clr_ev   = bus.dot_en && (line_q == PRE_LINE) && (dot_q == EVT_DOT);

        if (bus.dot_en) begin
            unique case (1'b1)
                skip: begin
                    dot_n  = 9'd0;
                    line_n = 9'd0;
                    odd_n  = ~odd_q;
                end
                wrap_dot: begin
                    dot_n = 9'd0;
                    if (line_q == LAST_LINE) begin
                        line_n = 9'd0;
                        odd_n  = ~odd_q;
                    end else begin
                        line_n = line_q + 9'd1;
                    end
                end
                default: dot_n = dot_q + 9'd1;
            endcase
        end

        if (clr_ev) begin
            vblank_n  = 1'b0;
            sprite0_n = 1'b0;
            ovf_n     = 1'b0;
        end else begin
            if (bus.status_rd) begin
                vblank_n = 1'b0;
            end else if (set_ev) begin
                vblank_n = 1'b1;
            end
            sprite0_n = sprite0_q | bus.sprite0_set;
            ovf_n     = ovf_q | bus.sprite_ovf_set;
        end

        nmi_level_n = vblank_n & bus.ctrl_nmi_en;
        nmi_pulse_n = nmi_level_q & ~nmi_prev_q;
    end

    // State registers; reset dominates every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            dot_q       <= 9'd0;
            line_q      <= 9'd0;
            odd_q       <= 1'b0;
            vblank_q    <= 1'b0;
            sprite0_q   <= 1'b0;
            ovf_q       <= 1'b0;
            nmi_level_q <= 1'b0;
            nmi_prev_q  <= 1'b0;
            nmi_pulse_q <= 1'b0;
        end else begin
            dot_q       <= dot_n;
            line_q      <= line_n;
            odd_q       <= odd_n;
            vblank_q    <= vblank_n;
            sprite0_q   <= sprite0_n;
            ovf_q       <= ovf_n;
            nmi_level_q <= nmi_level_n;
            nmi_prev_q  <= nmi_level_q;
            nmi_pulse_q <= nmi_pulse_n;
        end
    end

    assign bus.ppu_status = {vblank_q, sprite0_q, ovf_q, 5'b0};
    assign bus.nmi_level  = nmi_level_q;
    assign bus.nmi_pulse  = nmi_pulse_q;
    assign bus.dot        = dot_q;
    assign bus.scanline   = line_q;
    assign bus.odd_frame  = odd_q;

endmodule
